// File: rtl/fsm_seq_pkg.sv
// Shared state encodings, default display codes and synchronizer slot indices
// for the start/advance sequencer.
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  localparam logic [7:0] DISP_IDLE  = 8'd0;
  localparam logic [7:0] DISP_COUNT = 8'd10;
  localparam logic [7:0] DISP_WAIT  = 8'd5;
  localparam logic [7:0] DISP_DONE  = 8'd15;

  localparam int NUM_SYNC   = 3;
  localparam int SYNC_START = 0;
  localparam int SYNC_ADV   = 1;
  localparam int SYNC_ABORT = 2;

endpackage

// File: rtl/fsm_sequencer_sync_edge.sv
// Two-flop synchronizer with registered level and a one-cycle rising-edge pulse
// that appears in the same cycle the synchronized level first goes high.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic lvl_o,
  output logic edge_o
);

  logic s1_q, s2_q, edge_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      edge_q <= s1_q & ~s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/fsm_sequencer.sv
// Start/count/wait/done sequencer: counts prescaled ticks up to a latched target,
// then steps through WAIT and DONE on advance edges; abort returns to IDLE.
module fsm_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int         COUNT_W  = 8,
  parameter int         PRESCALE = 10_000_000,
  parameter logic [7:0] D_IDLE   = DISP_IDLE,
  parameter logic [7:0] D_COUNT  = DISP_COUNT,
  parameter logic [7:0] D_WAIT   = DISP_WAIT,
  parameter logic [7:0] D_DONE   = DISP_DONE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  logic               abort,
  input  logic [COUNT_W-1:0] count_target,
  output logic [7:0]         disp,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [NUM_SYNC-1:0] sync_in, sync_lvl, sync_edge_p;
  logic [2:0]          sync_unused;

  assign sync_in[SYNC_START] = start;
  assign sync_in[SYNC_ADV]   = advance;
  assign sync_in[SYNC_ABORT] = abort;

  for (genvar i = 0; i < NUM_SYNC; i++) begin : g_sync
    sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .in_i   (sync_in[i]),
      .lvl_o  (sync_lvl[i]),
      .edge_o (sync_edge_p[i])
    );
  end

  // Abort is level-only; start/advance are edge-only.
  assign sync_unused = {sync_lvl[SYNC_START], sync_lvl[SYNC_ADV], sync_edge_p[SYNC_ABORT]};

  logic start_e, adv_e, abort_l;
  assign start_e = sync_edge_p[SYNC_START];
  assign adv_e   = sync_edge_p[SYNC_ADV];
  assign abort_l = sync_lvl[SYNC_ABORT];

  state_e             state_q;
  logic [7:0]         disp_q;
  logic [COUNT_W-1:0] count_q, target_q;
  logic [PRE_W-1:0]   pre_q;
  logic               busy_q, done_q;
  logic               tick;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      disp_q   <= D_IDLE;
      count_q  <= '0;
      target_q <= '0;
      pre_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_l) begin
        state_q <= ST_IDLE;
        disp_q  <= D_IDLE;
        busy_q  <= 1'b0;
        count_q <= '0;
        pre_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            count_q <= '0;
            if (start_e) begin
              state_q  <= ST_COUNT;
              disp_q   <= D_COUNT;
              busy_q   <= 1'b1;
              target_q <= count_target;
              pre_q    <= '0;
            end
          end
          ST_COUNT: begin
            if (tick) begin
              pre_q <= '0;
              // Exit compares before incrementing, so count never wraps.
              if (count_q == target_q) begin
                state_q <= ST_WAIT;
                disp_q  <= D_WAIT;
              end else begin
                count_q <= count_q + 1'b1;
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          ST_WAIT: begin
            if (adv_e) begin
              state_q <= ST_DONE;
              disp_q  <= D_DONE;
              done_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (adv_e) begin
              state_q <= ST_IDLE;
              disp_q  <= D_IDLE;
              busy_q  <= 1'b0;
              count_q <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            disp_q  <= D_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end
        endcase
      end
    end
  end

  assign state = state_q;
  assign disp  = disp_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Bench for fsm_sequencer: directed and randomized sequences checked against a
// timing model (3-edge input latency, (N+1)*PRESCALE cycles in COUNT).
module tb_fsm_sequencer;
  localparam int P = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, advance = 1'b0, abort = 1'b0;
  logic [W-1:0] count_target = '0;
  logic [7:0]   disp;
  logic [2:0]   state;
  logic [W-1:0] count;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  fsm_sequencer #(.COUNT_W(W), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .start(start), .advance(advance), .abort(abort),
    .count_target(count_target), .disp(disp), .state(state), .count(count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] disp_of(input int s);
    case (s)
      1:       return 8'd10;
      2:       return 8'd5;
      3:       return 8'd15;
      default: return 8'd0;
    endcase
  endfunction

  // Start edge: no change for two edges, COUNT on the third.
  task automatic start_seq(input logic [W-1:0] tgt);
    count_target = tgt;
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (i < 3) begin
        if (state !== 3'd0) begin
          bad++; $display("FAIL start_latency edge=%0d state=%0d want=0", i, state);
        end
      end else if ({state, disp, busy, count, done} !== {3'd1, 8'd10, 1'b1, {W{1'b0}}, 1'b0}) begin
        bad++; $display("FAIL start_entry state=%0d disp=%0d busy=%0b count=%0d done=%0b want 1/10/1/0/0",
                        state, disp, busy, count, done);
      end
    end
    start = 1'b0;
  endtask

  // Count phase: count = min(i/P, n); WAIT on edge (n+1)*P after entry.
  task automatic run_count(input int n, input bit chg);
    int last, es, ec;
    last = (n + 1) * P;
    for (int i = 1; i <= last; i++) begin
      if (chg && i == 2) count_target = W'($urandom_range(0, 255));
      step();
      es = (i == last) ? 2 : 1;
      ec = (i / P < n) ? i / P : n;
      total++;
      if ({state, disp, busy, count, done} !== {3'(es), disp_of(es), 1'b1, W'(ec), 1'b0}) begin
        bad++; $display("FAIL count_phase tgt=%0d i=%0d state=%0d count=%0d disp=%0d want %0d/%0d/%0d",
                        n, i, state, count, disp, es, ec, disp_of(es));
      end
    end
  endtask

  // One advance pulse: from -> to on the third edge, done only when entering DONE.
  task automatic do_advance(input int from, input int to, input int ec);
    advance = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) advance = 1'b0;
      step();
      total++;
      if (i < 3) begin
        if (state !== 3'(from)) begin
          bad++; $display("FAIL adv_latency i=%0d state=%0d want=%0d", i, state, from);
        end
      end else if ({state, disp, busy, count, done} !==
                   {3'(to), disp_of(to), to != 0, W'(ec), (i == 3) && (to == 3)}) begin
        bad++; $display("FAIL adv_step i=%0d state=%0d disp=%0d busy=%0b count=%0d done=%0b want to=%0d count=%0d",
                        i, state, disp, busy, count, done, to, ec);
      end
    end
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++;
    if ({state, disp, count, busy, done} !== '0) begin
      bad++; $display("FAIL reset_async state=%0d disp=%0d count=%0d busy=%0b done=%0b want all 0",
                      state, disp, count, busy, done);
    end
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({state, disp, count, busy, done} !== '0) begin
      bad++; $display("FAIL reset_release state=%0d disp=%0d want 0/0", state, disp);
    end
  endtask

  task automatic test_target3();
    start_seq(8'd3);
    run_count(3, 1'b0);
    do_advance(2, 3, 3);
    do_advance(3, 0, 0);
  endtask

  task automatic test_bounds();
    start_seq(8'd0);
    run_count(0, 1'b0);
    do_advance(2, 3, 0);
    do_advance(3, 0, 0);
    start_seq(8'd255);
    run_count(255, 1'b0);
    do_advance(2, 3, 255);
    do_advance(3, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int  n;
      bit  chg;
      n   = $urandom_range(0, 6);
      chg = 1'($urandom_range(0, 1));
      start_seq(W'(n));
      run_count(n, chg);
      do_advance(2, 3, n);
      do_advance(3, 0, 0);
    end
  endtask

  task automatic test_abort();
    start_seq(8'd5);
    for (int i = 0; i < 2 * P; i++) step();
    total++;
    if (count !== 8'd2) begin
      bad++; $display("FAIL abort_precount count=%0d want=2", count);
    end
    abort = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (i < 3) begin
        if (state !== 3'd1) begin
          bad++; $display("FAIL abort_latency i=%0d state=%0d want=1", i, state);
        end
      end else if ({state, disp, busy, count} !== {3'd0, 8'd0, 1'b0, {W{1'b0}}}) begin
        bad++; $display("FAIL abort_idle state=%0d disp=%0d busy=%0b count=%0d want 0", state, disp, busy, count);
      end
    end
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      for (int i = 0; i < 4; i++) step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) step();
      total++;
      if ({state, busy} !== {3'd0, 1'b0}) begin
        bad++; $display("FAIL abort_hold_start k=%0d state=%0d busy=%0b want 0", k, state, busy);
      end
    end
    abort = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL abort_release state=%0d want=0", state);
    end
  endtask

  task automatic test_reset_mid();
    start_seq(8'd1);
    run_count(1, 1'b0);
    reset = 1'b0;
    #2;
    total++;
    if ({state, disp, done, busy, count} !== '0) begin
      bad++; $display("FAIL reset_mid_wait state=%0d disp=%0d done=%0b busy=%0b count=%0d want 0",
                      state, disp, done, busy, count);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    start_seq(8'd2);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    #2;
    total++;
    if ({state, count, busy} !== '0) begin
      bad++; $display("FAIL reset_mid_count state=%0d count=%0d busy=%0b want 0", state, count, busy);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if ({state, count, done} !== '0) begin
        bad++; $display("FAIL reset_no_tick i=%0d state=%0d count=%0d want 0", i, state, count);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_seq(8'd0);
    run_count(0, 1'b0);
    advance = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      total++;
      if ({state, done} !== {(i >= 3) ? 3'd3 : 3'd2, i == 3}) begin
        bad++; $display("FAIL adv_held i=%0d state=%0d done=%0b want %0d/%0b", i, state, done, (i >= 3) ? 3 : 2, i == 3);
      end
    end
    advance = 1'b0;
    for (int i = 0; i < 3; i++) step();
    start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if ({state, disp, busy} !== {3'd3, 8'd15, 1'b1}) begin
      bad++; $display("FAIL start_in_done state=%0d disp=%0d want 3/15", state, disp);
    end
    do_advance(3, 0, 0);
  endtask

  initial begin
    test_reset();
    test_target3();
    test_bounds();
    test_random();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fsm_sequencer.md
FSM_SEQUENCER -- requirements
Module: fsm_sequencer

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, meaning counter and target width.
REQ-002 SHALL have parameter PRESCALE, default 10_000_000, meaning clk cycles per count tick (minimum 1).
REQ-003 SHALL have parameters D_IDLE/D_COUNT/D_WAIT/D_DONE, defaults 8'd0/8'd10/8'd5/8'd15, meaning the display code driven in each state.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, asynchronous level; a rising edge leaves IDLE.
REQ-007 SHALL have port advance, input, 1, asynchronous level; a rising edge steps WAIT->DONE and DONE->IDLE.
REQ-008 SHALL have port abort, input, 1, asynchronous level; while synchronized high, any state returns to IDLE.
REQ-009 SHALL have port count_target, input, COUNT_W, the terminal count, sampled on leaving IDLE.
REQ-010 SHALL have port disp, output, 8, the registered display code.
REQ-011 SHALL have port state, output, 3, the registered state encoding.
REQ-012 SHALL have port count, output, COUNT_W, the current counter value.
REQ-013 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse on entry to DONE.

Function
REQ-015 SHALL pass start, advance and abort through 2-flop synchronizers; start and advance SHALL also pass through rising-edge detectors, giving one cycle of edge per 0->1 transition.
REQ-016 SHALL apply an input rising before clk edge k as a state change at edge k+3 (k+1 sync1, k+2 sync2 plus edge, k+3 state register).
REQ-017 SHALL use states IDLE=3'd0, COUNT=3'd1, WAIT=3'd2, DONE=3'd3; codes 4-7 SHALL go to IDLE on the next edge.
REQ-018 SHALL go IDLE->COUNT on a start edge, latching count_target into the target register and clearing count and the prescaler.
REQ-019 SHALL, in COUNT, run the prescaler 0..PRESCALE-1, with tick asserted in the cycle the prescaler equals PRESCALE-1; PRESCALE=1 SHALL assert tick every cycle.
REQ-020 SHALL, on tick in COUNT, go to WAIT if count==target (count unchanged); otherwise count SHALL increment by 1.
REQ-021 SHALL, with target=0, enter WAIT on the first tick with count=0; with target=N, remain in COUNT for N+1 ticks.
REQ-022 SHALL never let count wrap; since target<=2^COUNT_W-1, COUNT exits at the maximum value.
REQ-023 SHALL ignore count_target changes after the target is latched.
REQ-024 SHALL go WAIT->DONE on an advance edge and DONE->IDLE on an advance edge; WAIT and DONE SHALL otherwise hold.
REQ-025 SHALL ignore start edges outside IDLE and advance edges in IDLE and COUNT.
REQ-026 SHALL, when synchronized abort is high, go to IDLE from any state at the next edge, taking priority over every other transition; IDLE SHALL hold while abort is high, even with a start edge.
REQ-027 SHALL keep count in IDLE at 0; count SHALL hold its final value through WAIT and DONE.
REQ-028 SHALL update disp, state and busy in the same edge as the state register, with disp equal to the D_* code for the next state (D_IDLE for illegal states).
REQ-029 SHALL assert done in exactly the first cycle in DONE.

Reset
REQ-030 SHALL, on reset low, asynchronously set state=IDLE, disp=D_IDLE, count=0, target=0, prescaler=0, busy=0, done=0, and clear all synchronizer and edge flops to 0.
REQ-031 SHALL, when reset is asserted mid-COUNT, abort the sequence with no further tick; after release, a start edge is required.
REQ-032 SHALL release reset synchronously to clk, which is guaranteed by the system.

Structure
REQ-033 SHALL put the state encodings and default display codes in shared package fsm_seq_pkg.
REQ-034 SHALL use sub-module sync_edge (2-flop sync, registered level out, rising-edge pulse out, same reset), instantiated three times.
REQ-035 SHALL keep the RTL in the range of 120-400 lines.

Verification
REQ-036 SHALL run the bench with PRESCALE=4 and COUNT_W=8.
REQ-037 Scenario: start edge with target=3 -> state=1 and disp=10 at edge k+3; count steps 0,1,2,3 every 4 cycles; WAIT (disp=5) on the 4th tick after entry.
REQ-038 Scenario: in WAIT, advance edge -> state=3, disp=15, done high for 1 cycle; second advance edge -> state=0, disp=0, busy=0, count=0.
REQ-039 Scenario: target=0 -> WAIT after exactly 4 cycles in COUNT, count=0; target=255 -> WAIT with count=255, no wrap.
REQ-040 Scenario: abort high mid-COUNT (count=2) -> IDLE 3 edges later; start edges while abort is held -> remain IDLE.
REQ-041 Scenario: reset low mid-WAIT -> immediate asynchronous state=0, disp=0, done=0; count_target changed mid-COUNT -> exit at the original target.
REQ-042 Scenario: advance held high for 20 cycles in WAIT -> exactly one step to DONE; start pulse in DONE -> ignored.
